branch_target_predictor: RTL
============================

// Module: branch_target_predictor
// PURPOSE
//  IF-stage direction/target predictor; the producer end of the branch-prediction loop closed by the EX-stage branch resolver.
//  Same-cycle lookup on the fetch PC gives predicted taken plus next-fetch target.
//  Trained on the clock edge from EX resolution results (is_branch, taken, resolved target, PC, mispredict flag).
//  Also keeps branch/mispredict performance counters.
// PARAMETERS
//  BTB_IDX_W   6   log2 BTB entries (64); index = pc[BTB_IDX_W+1:2], tag = pc[31:BTB_IDX_W+2]
//  BHT_IDX_W   8   log2 BHT 2-bit counters (256); index = pc[BHT_IDX_W+1:2]; used only with BRANCH_PREDICT_BHT_EN
// PORTS
//  clk               in   1   single clock, rising edge
//  rst               in   1   synchronous, active-high reset
//  if_pc             in   32  fetch-stage PC being looked up
//  pred_taken        out  1   predicted taken for if_pc (combinational)
//  pred_target       out  32  next fetch PC: BTB target if pred_taken, else if_pc+4
//  ex_is_branch      in   1   EX holds a conditional branch
//  ex_stall          in   1   EX stalled; suppresses training and counting
//  ex_taken          in   1   resolved direction
//  ex_pc             in   32  PC of the resolved branch
//  ex_target         in   32  resolved taken-target (br_target)
//  ex_predict_wrong  in   1   resolved direction != predicted direction
//  br_cnt            out  32  resolved-branch count
//  miss_cnt          out  32  mispredicted-branch count
// BEHAVIOUR
//  - Training enable: upd = ex_is_branch & ~ex_stall. It fires once per branch.
//  - Lookup is asynchronous read of registered tables.
//    - hit = valid[idx] & (tag[idx] == if_pc tag).
//    - pc[1:0] ignored everywhere.
//  - Same-cycle read/write to one entry: lookup returns the pre-update contents. The new state is visible the next cycle.
//  - Reset (rst=1 at posedge) has priority over upd.
//    - Clears every BTB valid bit.
//    - Sets every BHT counter to 2'b01 (weakly not-taken).
//    - Zeroes br_cnt and miss_cnt.
//    - After reset: pred_taken=0 and pred_target=if_pc+4 for any PC.
//  - BTB write on upd & ex_taken: valid=1, tag=ex_pc tag, target=ex_target. This overwrites any aliasing entry with a different tag.
//  - Counters on upd:
//    - br_cnt += 1.
//    - miss_cnt += 1 if ex_predict_wrong.
//    - Both wrap modulo 2^32.
//  - No state changes when ex_stall=1 or ex_is_branch=0.
//  - Width rules:
//    - pred_target = if_pc + 32'd4, truncating at 2^32.
//    - BTB stores 32-bit targets unmodified.
// CONFIGURATION
//  Macro BRANCH_PREDICT_BHT_EN.
//  - Defined:
//    - pred_taken = hit & bht[bidx][1].
//    - On upd, the BHT counter saturating-increments (max 2'b11) if ex_taken, else saturating-decrements (min 2'b00).
//    - The BHT trains even on a BTB miss.
//    - BTB entries are never invalidated.
//  - Undefined:
//    - No BHT storage.
//    - pred_taken = hit.
//    - upd & ~ex_taken & BTB hit on ex_pc clears that entry's valid bit (1-bit prediction).
// STRUCTURE
//  - Parameters.v holds:
//    - default BTB_IDX_W/BHT_IDX_W;
//    - the 2-bit counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
//    - BHT reset value WNT.
//  - One sub-module: branch_history_table. It holds the counter array, async read port, and saturating update.
//    It is instantiated only under BRANCH_PREDICT_BHT_EN.
//  - BTB arrays and perf counters stay in this module.
// TESTING
//  1. rst; if_pc=0x100 -> pred_taken=0, pred_target=0x104; br_cnt=miss_cnt=0.
//  2. upd ex_pc=0x100 taken ex_target=0x80; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80 (both configs; BHT 01->10).
//  3. After 2, if_pc=0x200 (same BTB index, different tag, BTB_IDX_W=6) -> pred_taken=0, pred_target=0x204.
//  4. ex_pc=0x100 taken x3 then not-taken x1:
//     - with BHT: counter 11->10, pred_taken=1;
//     - without: entry invalidated, pred_taken=0, pred_target=0x104.
//  5. if_pc=ex_pc=0x40 in the cycle of a first taken update -> pred_taken=0 that cycle, 1 the next.
//  6. ex_is_branch=1, ex_predict_wrong=1, ex_stall=1 for 3 cycles then 0 for 1 -> br_cnt=1, miss_cnt=1.
//     Then assert rst alongside upd -> both counters 0, all lookups miss.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// rtl/branch_target_predictor_pkg.sv - shared sizes, 2-bit counter encodings and saturating-counter helper
package branch_target_predictor_pkg;

   localparam int BTB_IDX_W_DEFAULT = 6;
   localparam int BHT_IDX_W_DEFAULT = 8;

   // Direction counter: bit 1 is the taken prediction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_t;

   localparam bht_state_t BHT_RESET = WNT;

   // Saturating step of a 2-bit counter toward the resolved direction
   function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
      bht_state_t nxt;
      nxt = cur;
      case (cur)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
         default: nxt = BHT_RESET;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating direction counters with async read and clocked update
module branch_history_table
   import branch_target_predictor_pkg::*;
#(
   parameter int IDX_W = BHT_IDX_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_state_t       rd_state,
   input  logic             upd,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int ENTRIES = 1 << IDX_W;

   bht_state_t ctr [ENTRIES];

   // Lookup sees the registered counter, so a same-cycle update is visible next cycle
   assign rd_state = ctr[rd_idx];

   // Reset every counter to weakly not-taken; otherwise step the trained entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i] <= BHT_RESET;
         end
      end else if (upd) begin
         ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - IF-stage BTB lookup, EX-stage training, perf counters; BHT under BRANCH_PREDICT_BHT_EN
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int BTB_IDX_W = BTB_IDX_W_DEFAULT,
   parameter int BHT_IDX_W = BHT_IDX_W_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_is_branch,
   input  logic        ex_stall,
   input  logic        ex_taken,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_predict_wrong,
   output logic [31:0] br_cnt,
   output logic [31:0] miss_cnt
);

   localparam int TAG_W   = 32 - BTB_IDX_W - 2;
   localparam int ENTRIES = 1 << BTB_IDX_W;

   if (BTB_IDX_W < 1 || BTB_IDX_W > 29) begin : g_bad_btb_idx_w
      $error("BTB_IDX_W out of range");
   end
   if (BHT_IDX_W < 1 || BHT_IDX_W > 30) begin : g_bad_bht_idx_w
      $error("BHT_IDX_W out of range");
   end

   logic [ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]   btb_tag    [ENTRIES];
   logic [31:0]        btb_target [ENTRIES];

   logic [BTB_IDX_W-1:0] if_idx;
   logic [TAG_W-1:0]     if_tag;
   logic [BTB_IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0]     ex_tag;
   logic                 if_hit;
   logic                 upd;

   assign if_idx = if_pc[BTB_IDX_W+1:2];
   assign if_tag = if_pc[31:BTB_IDX_W+2];
   assign ex_idx = ex_pc[BTB_IDX_W+1:2];
   assign ex_tag = ex_pc[31:BTB_IDX_W+2];
   assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
   assign upd    = ex_is_branch && !ex_stall;

`ifdef BRANCH_PREDICT_BHT_EN
   bht_state_t bht_state;

   branch_history_table #(
      .IDX_W (BHT_IDX_W)
   ) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (if_pc[BHT_IDX_W+1:2]),
      .rd_state  (bht_state),
      .upd       (upd),
      .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
      .upd_taken (ex_taken)
   );

   assign pred_taken = if_hit && bht_state[1];

   logic unused_bits;
   assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], bht_state[0]};

   // Valid bits only ever set here; the counters decide direction
   always_ff @(posedge clk) begin
      if (rst) begin
         btb_valid <= '0;
      end else if (upd && ex_taken) begin
         btb_valid[ex_idx] <= 1'b1;
      end
   end
`else
   logic ex_hit;

   assign ex_hit     = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
   assign pred_taken = if_hit;

   logic unused_bits;
   assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

   // 1-bit prediction: a taken branch installs its entry, a not-taken hit drops it
   always_ff @(posedge clk) begin
      if (rst) begin
         btb_valid <= '0;
      end else if (upd && ex_taken) begin
         btb_valid[ex_idx] <= 1'b1;
      end else if (upd && ex_hit) begin
         btb_valid[ex_idx] <= 1'b0;
      end
   end
`endif

   assign pred_target = pred_taken ? btb_target[if_idx] : (if_pc + 32'd4);

   // Tag and target payload are only meaningful under a valid bit, so they need no reset
   always_ff @(posedge clk) begin
      if (!rst && upd && ex_taken) begin
         btb_tag[ex_idx]    <= ex_tag;
         btb_target[ex_idx] <= ex_target;
      end
   end

   // Performance counters, frozen while EX is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt   <= '0;
         miss_cnt <= '0;
      end else if (upd) begin
         br_cnt <= br_cnt + 32'd1;
         if (ex_predict_wrong) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end

endmodule
